// File: rtl/vx_icache_fetch_stage_pkg.sv
// Shared configuration and payload types for the I-cache fetch stage.
// Fetch metadata is parked per warp; the response payload is what decode sees.
package vx_icache_fetch_stage_pkg;

  localparam int unsigned NUM_WARPS   = 4;
  localparam int unsigned NUM_THREADS = 4;
  localparam int unsigned UUID_BITS   = 44;
  localparam int unsigned NW_BITS     = $clog2(NUM_WARPS);

  typedef struct packed {
    logic [UUID_BITS-1:0]   uuid;
    logic [NUM_THREADS-1:0] tmask;
    logic [31:0]            pc;
  } fetch_meta_t;

  typedef struct packed {
    fetch_meta_t        meta;
    logic [NW_BITS-1:0] wid;
    logic [31:0]        instr;
  } fetch_rsp_t;

endpackage

// File: rtl/vx_fetch_rsp_buf.sv
// One-entry valid/ready pipe register for the fetch response payload.
// Accepts a new entry whenever empty or draining in the same cycle.
module vx_fetch_rsp_buf
  import vx_icache_fetch_stage_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  fetch_rsp_t in_data,
  output logic       in_ready,
  output logic       out_valid,
  output fetch_rsp_t out_data,
  input  logic       out_ready
);

  logic       valid_q, valid_d;
  fetch_rsp_t data_q, data_d;

  assign in_ready = ~valid_q | out_ready;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (in_valid && in_ready) begin
      valid_d = 1'b1;
      data_d  = in_data;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/vx_icache_fetch_stage.sv
// Instruction fetch stage: forwards per-warp fetches to the I-cache, parks their
// metadata by warp id, and re-pairs out-of-order cache responses by tag.
module vx_icache_fetch_stage
  import vx_icache_fetch_stage_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,

  input  logic                   ifetch_req_valid,
  input  logic [UUID_BITS-1:0]   ifetch_req_uuid,
  input  logic [NUM_THREADS-1:0] ifetch_req_tmask,
  input  logic [NW_BITS-1:0]     ifetch_req_wid,
  input  logic [31:0]            ifetch_req_PC,
  output logic                   ifetch_req_ready,

  output logic                   icache_req_valid,
  output logic [29:0]            icache_req_addr,
  output logic [NW_BITS-1:0]     icache_req_tag,
  input  logic                   icache_req_ready,

  input  logic                   icache_rsp_valid,
  input  logic [31:0]            icache_rsp_data,
  input  logic [NW_BITS-1:0]     icache_rsp_tag,
  output logic                   icache_rsp_ready,

  output logic                   ifetch_rsp_valid,
  output logic [UUID_BITS-1:0]   ifetch_rsp_uuid,
  output logic [NUM_THREADS-1:0] ifetch_rsp_tmask,
  output logic [NW_BITS-1:0]     ifetch_rsp_wid,
  output logic [31:0]            ifetch_rsp_PC,
  output logic [31:0]            ifetch_rsp_instr,
  input  logic                   ifetch_rsp_ready,

  output logic [NUM_WARPS-1:0]   pending_mask,
  output logic                   busy
);

  logic [NUM_WARPS-1:0] pending_q, pending_d;
  fetch_meta_t          meta_q [NUM_WARPS];
  fetch_rsp_t           rsp_in, rsp_out;
  logic                 req_blocked, req_fire, rsp_fire;

  // A warp with a fetch in flight may not issue again: its table slot is live.
  assign req_blocked      = pending_q[ifetch_req_wid];
  assign icache_req_valid = ifetch_req_valid & ~req_blocked;
  assign ifetch_req_ready = icache_req_ready & ~req_blocked;
  assign icache_req_addr  = ifetch_req_PC[31:2];
  assign icache_req_tag   = ifetch_req_wid;

  assign req_fire = ifetch_req_valid & ifetch_req_ready;
  assign rsp_fire = icache_rsp_valid & icache_rsp_ready;

  always_comb begin
    pending_d = pending_q;
    if (rsp_fire) pending_d[icache_rsp_tag] = 1'b0;
    if (req_fire) pending_d[ifetch_req_wid] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) pending_q <= '0;
    else       pending_q <= pending_d;
  end

  // Metadata table carries no reset; pending bits guard every read.
  always_ff @(posedge clk) begin
    if (req_fire) begin
      meta_q[ifetch_req_wid] <= '{uuid: ifetch_req_uuid, tmask: ifetch_req_tmask,
                                  pc: ifetch_req_PC};
    end
  end

  assign rsp_in = '{meta: meta_q[icache_rsp_tag], wid: icache_rsp_tag, instr: icache_rsp_data};

  vx_fetch_rsp_buf u_rsp_buf (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (icache_rsp_valid),
    .in_data   (rsp_in),
    .in_ready  (icache_rsp_ready),
    .out_valid (ifetch_rsp_valid),
    .out_data  (rsp_out),
    .out_ready (ifetch_rsp_ready)
  );

  assign ifetch_rsp_uuid  = rsp_out.meta.uuid;
  assign ifetch_rsp_tmask = rsp_out.meta.tmask;
  assign ifetch_rsp_PC    = rsp_out.meta.pc;
  assign ifetch_rsp_wid   = rsp_out.wid;
  assign ifetch_rsp_instr = rsp_out.instr;

  assign pending_mask = pending_q;
  assign busy         = (|pending_q) | ifetch_rsp_valid;

  a_rsp_tag_pending : assert property (@(posedge clk) disable iff (reset)
    rsp_fire |-> pending_q[icache_rsp_tag]);

  a_req_pc_aligned : assert property (@(posedge clk) disable iff (reset)
    req_fire |-> (ifetch_req_PC[1:0] == 2'b00));

endmodule
